// File: rtl/column_pkg.sv
// Shared constants and state encoding for the column sequencer.
package column_pkg;

    localparam int NUM_COLS = 25;
    localparam int PIPE_W   = 64;
    localparam int SETTLE   = 2;
    localparam int COL_W    = 5;
    localparam int NUM_W    = 32;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OFFER   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures how long the reader's pipe word needs to settle.
// Loading sets SETTLE-1; the zero flag marks the final settle cycle.
module settle_timer
    import column_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE - 1);
    localparam logic [SETTLE_W-1:0] ONE      = SETTLE_W'(1);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Next count: reload on request, otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/column_sequencer.sv
// Upstream controller for the bit-column reader: strobes each column once,
// waits for the pipe word to settle, latches it and offers it downstream.
module column_sequencer
    import column_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              readData,
    output logic [NUM_W-1:0]  num,
    input  logic [PIPE_W-1:0] pipe,
    output logic              col_valid,
    input  logic              col_ready,
    output logic [PIPE_W-1:0] col_data,
    output logic [COL_W-1:0]  col_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [PIPE_W-1:0]   col_data_q, col_data_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic                read_data_q, read_data_d;
    logic                col_valid_q, col_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timer_load;
    logic                timer_zero;

    settle_timer u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .zero  (timer_zero)
    );

    // Next-state, datapath and output decode; outputs follow the next state
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        col_data_d = col_data_q;
        col_idx_d  = col_idx_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_d   = '0;
                    state_d = ST_ASSERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                timer_load = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_zero) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                col_data_d = pipe;
                col_idx_d  = col_q;
                state_d    = ST_OFFER;
            end
            ST_OFFER: begin
                // col_valid is high throughout OFFER, so col_ready alone
                // completes the handshake here.
                if (col_ready) begin
                    if (col_q == LAST_COL) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d   = col_q + COL_ONE;
                        state_d = ST_ASSERT;
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_data_d = (state_d == ST_ASSERT);
        col_valid_d = (state_d == ST_OFFER);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        if (state_d == ST_ASSERT) begin
            num_d = {{(NUM_W - COL_W){1'b0}}, col_d};
        end else begin
            num_d = num_q;
        end
    end

    // State, datapath and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            num_q       <= '0;
            col_data_q  <= '0;
            col_idx_q   <= '0;
            read_data_q <= 1'b0;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            num_q       <= num_d;
            col_data_q  <= col_data_d;
            col_idx_q   <= col_idx_d;
            read_data_q <= read_data_d;
            col_valid_q <= col_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign readData  = read_data_q;
    assign num       = num_q;
    assign col_valid = col_valid_q;
    assign col_data  = col_data_q;
    assign col_idx   = col_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_column_sequencer.sv
// Directed bench for column_sequencer with a simple reader model.
module tb_column_sequencer;

    localparam int NCOLS = 25;
    localparam int GAP   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        readData;
    logic [31:0] num;
    logic [63:0] pipe = 64'd0;
    logic        col_valid;
    logic        col_ready = 1'b0;
    logic [63:0] col_data;
    logic [4:0]  col_idx;
    logic        busy;
    logic        done;

    int checks_total  = 0;
    int checks_passed = 0;

    column_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .readData  (readData),
        .num       (num),
        .pipe      (pipe),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .col_idx   (col_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reader model: returns the strobed column number one cycle after readData.
    always @(posedge clk) begin
        if (readData) pipe <= {59'd0, num[4:0]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_readData"}, {63'd0, readData}, 64'd0);
        check({tag, "_num"}, {32'd0, num}, 64'd0);
        check({tag, "_col_valid"}, {63'd0, col_valid}, 64'd0);
        check({tag, "_col_data"}, col_data, 64'd0);
        check({tag, "_col_idx"}, {59'd0, col_idx}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    // Runs one whole frame cycle by cycle; returns at the cycle showing done.
    task automatic run_frame(input int stall_col, input int stall_len,
                             input int poke_col, input bit hold);
        int pulses, accepted, dones, last_rd, last_acc, stall_cnt, ready_ret;
        bit fin;
        pulses = 0; accepted = 0; dones = 0; last_rd = 0;
        last_acc = -10; stall_cnt = 0; ready_ret = -1; fin = 1'b0;
        col_ready = 1'b1;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        check("first_rd", {63'd0, readData}, 64'd1);
        for (int c = 0; c < 400 && !fin; c++) begin
            if (c > 0) step();
            if (!hold) start = 1'b0;
            if (readData) begin
                check("rd_num", {32'd0, num}, 64'(pulses));
                if (pulses > 0)
                    check("rd_gap", 64'(c - last_rd),
                          (stall_col >= 0 && pulses == stall_col + 1) ? 64'(GAP + stall_len) : 64'(GAP));
                if (stall_col >= 0 && pulses == stall_col + 1)
                    check("resume", 64'(c), 64'(ready_ret + 1));
                if (pulses == poke_col) start = 1'b1;
                last_rd = c;
                pulses++;
            end
            if (done) begin
                dones++;
                check("done_cols", 64'(accepted), 64'(NCOLS));
                check("done_lat", 64'(c), 64'(last_acc + 1));
                check("done_busy", {63'd0, busy}, 64'd1);
                fin = 1'b1;
            end
            col_ready = 1'b1;
            if (col_valid) begin
                if (stall_col >= 0 && int'(col_idx) == stall_col && stall_cnt < stall_len) begin
                    col_ready = 1'b0;
                    stall_cnt++;
                    check("stall_idx", {59'd0, col_idx}, 64'(stall_col));
                    check("stall_data", col_data, 64'(stall_col));
                    check("stall_rd", {63'd0, readData}, 64'd0);
                    if (stall_cnt == stall_len) ready_ret = c + 1;
                end else begin
                    check("col_idx", {59'd0, col_idx}, 64'(accepted));
                    check("col_data", col_data, 64'(accepted));
                    last_acc = c;
                    accepted++;
                end
            end
        end
        check("pulses", 64'(pulses), 64'(NCOLS));
        check("dones", 64'(dones), 64'd1);
        if (stall_col >= 0) check("stall_len", 64'(stall_cnt), 64'(stall_len));
    endtask

    initial begin
        bit found;
        bit saw_done;
        bit saw_busy;

        // 1. Reset for three clocks.
        rst_n = 1'b0; start = 1'b0; col_ready = 1'b0;
        step(); step(); step();
        check_all_zero("reset");
        rst_n = 1'b1;
        // col_ready with nothing valid must not wake the block.
        col_ready = 1'b1;
        step(); step();
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_valid", {63'd0, col_valid}, 64'd0);

        // 2. Plain frame with col_ready held high.
        run_frame(-1, 0, -1, 1'b0);
        step();
        check("post_done", {63'd0, done}, 64'd0);
        check("post_busy", {63'd0, busy}, 64'd0);

        // 3. Ten-cycle stall in OFFER of column 3.
        run_frame(3, 10, -1, 1'b0);
        step();
        check("stall_post_busy", {63'd0, busy}, 64'd0);

        // 4. start pulsed while busy during column 7.
        run_frame(-1, 0, 7, 1'b0);
        saw_done = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("poke_extra_done", {63'd0, saw_done}, 64'd0);
        check("poke_extra_busy", {63'd0, saw_busy}, 64'd0);

        // 5. Reset during WAIT of column 10.
        col_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = (readData && num == 32'd0);
        for (int c = 0; c < 200 && !(readData && num == 32'd10); c++) step();
        found = found && readData && (num == 32'd10);
        check("abort_reach", {63'd0, found}, 64'd1);
        step();
        check("abort_in_wait", {63'd0, readData}, 64'd0);
        rst_n = 1'b0;
        step();
        check_all_zero("abort");
        rst_n = 1'b1;
        saw_done = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        check("abort_no_resume", {63'd0, saw_busy}, 64'd0);
        run_frame(-1, 0, -1, 1'b0);
        step();

        // 6. start held high: back-to-back frames, one IDLE cycle between.
        run_frame(-1, 0, -1, 1'b1);
        step();
        check("gap_idle_busy", {63'd0, busy}, 64'd0);
        check("gap_idle_rd", {63'd0, readData}, 64'd0);
        run_frame(-1, 0, -1, 1'b1);
        start = 1'b0;
        step();
        check("end_busy", {63'd0, busy}, 64'd0);
        step();
        check("end_rd", {63'd0, readData}, 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
